// File: rtl/ag_tcu_step_sequencer.sv
// Round-robin tile-MMA command sequencer for the AG tensor-core execute port.
// Optional performance counters are enabled by defining AG_TCU_SEQ_PERF_EN.
module ag_tcu_step_sequencer #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 8,
    parameter int MAX_OUT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    input  logic [NUM_REQ*4-1:0]   req_m_last,
    input  logic [NUM_REQ*4-1:0]   req_n_last,
    input  logic [NUM_REQ*9-1:0]   req_scale,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [TAG_W-1:0]       issue_tag,
    output logic [3:0]             issue_step_m,
    output logic [3:0]             issue_step_n,
    output logic                   issue_last,
    input  logic                   done_valid,
    output logic [8:0]             scale_combined,
    output logic                   cmd_done_valid,
    output logic [TAG_W-1:0]       cmd_done_tag,
    output logic                   err
`ifdef AG_TCU_SEQ_PERF_EN
    ,
    output logic [31:0]            perf_busy_cycles,
    output logic [31:0]            perf_stall_cycles
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t             state, state_next;
    logic [PTR_W-1:0]   rr_ptr, winner;
    logic               any_req, grant, fire, err_set;
    logic [CNT_W-1:0]   outstanding, outstanding_next;
    logic [3:0]         m_last, n_last, step_m_next, step_n_next;
    logic [TAG_W-1:0]   sel_tag;
    logic [3:0]         sel_m_last, sel_n_last;
    logic [8:0]         sel_scale;
    logic               retire_next;

    // Round-robin search starts one past the last winner; lowest offset wins.
    always_comb begin
        int idx;
        idx     = 0;
        winner  = rr_ptr;
        any_req = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (req_valid[idx]) begin
                winner  = PTR_W'(idx);
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        sel_tag    = req_tag[int'(winner)*TAG_W +: TAG_W];
        sel_m_last = req_m_last[int'(winner)*4 +: 4];
        sel_n_last = req_n_last[int'(winner)*4 +: 4];
        sel_scale  = req_scale[int'(winner)*9 +: 9];
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant) state_next = ISSUE;
            ISSUE:   if (fire && issue_last) state_next = DRAIN;
            DRAIN:   if (cmd_done_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: the only combinational handshake signals
    always_comb begin
        grant       = (state == IDLE) && any_req;
        issue_valid = (state == ISSUE) && (outstanding < CNT_W'(MAX_OUT));
        fire        = issue_valid && issue_ready;
        for (int i = 0; i < NUM_REQ; i++)
            req_ready[i] = grant && (winner == PTR_W'(i));
    end

    always_comb begin
        outstanding_next = outstanding;
        err_set          = 1'b0;
        if (fire && !done_valid) begin
            outstanding_next = outstanding + 1'b1;
        end else if (done_valid && !fire) begin
            if (outstanding == '0) err_set = 1'b1;
            else                   outstanding_next = outstanding - 1'b1;
        end
    end

    // n is the inner loop, m the outer.
    always_comb begin
        if (issue_step_n == n_last) begin
            step_n_next = 4'd0;
            step_m_next = issue_step_m + 4'd1;
        end else begin
            step_n_next = issue_step_n + 4'd1;
            step_m_next = issue_step_m;
        end
    end

    assign retire_next = (state == DRAIN) && !cmd_done_valid && (outstanding_next == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr         <= PTR_W'(NUM_REQ - 1);
            outstanding    <= '0;
            err            <= 1'b0;
            issue_tag      <= '0;
            issue_step_m   <= 4'd0;
            issue_step_n   <= 4'd0;
            issue_last     <= 1'b0;
            m_last         <= 4'd0;
            n_last         <= 4'd0;
            scale_combined <= 9'd0;
            cmd_done_valid <= 1'b0;
            cmd_done_tag   <= '0;
        end else begin
            outstanding    <= outstanding_next;
            err            <= err | err_set;
            cmd_done_valid <= retire_next;
            if (retire_next) cmd_done_tag <= issue_tag;
            if (grant) begin
                rr_ptr         <= winner;
                issue_tag      <= sel_tag;
                m_last         <= sel_m_last;
                n_last         <= sel_n_last;
                scale_combined <= sel_scale;
                issue_step_m   <= 4'd0;
                issue_step_n   <= 4'd0;
                issue_last     <= (sel_m_last == 4'd0) && (sel_n_last == 4'd0);
            end else if (fire) begin
                issue_step_m   <= step_m_next;
                issue_step_n   <= step_n_next;
                issue_last     <= (step_m_next == m_last) && (step_n_next == n_last);
            end
        end
    end

`ifdef AG_TCU_SEQ_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_busy_cycles  <= 32'd0;
            perf_stall_cycles <= 32'd0;
        end else begin
            if (state != IDLE) perf_busy_cycles <= perf_busy_cycles + 32'd1;
            if ((state == ISSUE) && !fire) perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule
